// File: rtl/accumulator_drain_controller.sv
// accumulator_drain_controller: runs one K-cycle accumulate pass over N accumulators and drains the sums one byte per beat
module accumulator_drain_controller #(
  parameter int N  = 4,
  parameter int K  = 4,
  parameter int CW = 2
) (
  input  logic            clk,
  input  logic            clear,
  input  logic            start,
  input  logic [8*N-1:0]  acc_vec,
  output logic            acc_clear,
  output logic            feed_en,
  output logic [7:0]      out_data,
  output logic [CW-1:0]   out_col,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            busy,
  output logic            done
);
  localparam int KW = $clog2(K + 1);
  typedef enum logic [1:0] {IDLE, ACCUM, CAPTURE, DRAIN} state_t;
  state_t             state_q, state_d;
  logic [KW-1:0]      cnt_q;
  logic [CW-1:0]      idx_q;
  logic [N-1:0][7:0]  buf_q;
  logic               last_beat;
  assign last_beat = state_q == DRAIN && out_ready && idx_q == CW'(N - 1);
  // next state; clear wins over every other condition
  always_comb
    state_d = clear ? IDLE :
              state_q == IDLE  ? (start ? ACCUM : IDLE) :
              state_q == ACCUM ? (cnt_q == KW'(K - 1) ? CAPTURE : ACCUM) :
              state_q == CAPTURE ? DRAIN :
              last_beat ? IDLE : DRAIN;
  // state, counters, capture buffer and registered control outputs
  always_ff @(posedge clk) begin
    state_q   <= state_d;
    acc_clear <= state_d == IDLE || state_d == DRAIN;
    feed_en   <= state_d == ACCUM;
    out_valid <= state_d == DRAIN;
    busy      <= state_d != IDLE;
    done      <= !clear && last_beat;
    cnt_q     <= (!clear && state_q == ACCUM) ? cnt_q + 1'b1 : '0;
    idx_q     <= (clear || state_q == CAPTURE || last_beat) ? '0 :
                 (state_q == DRAIN && out_ready) ? idx_q + 1'b1 : idx_q;
    buf_q     <= clear ? '0 : state_q == CAPTURE ? acc_vec : buf_q;
  end
  assign out_data = out_valid ? buf_q[idx_q] : 8'h00;
  assign out_col  = idx_q;
endmodule

// File: tb/tb_accumulator_drain_controller.sv
// tb_accumulator_drain_controller: scoreboard bench with an accumulator-row model for the drain controller
module tb_accumulator_drain_controller;
  localparam int N = 4, K = 4;
  logic clk = 0;
  always #5 clk = ~clk;
  logic clear = 1, start = 0, out_ready = 0;
  logic [8*N-1:0] acc_vec;
  logic acc_clear, feed_en, out_valid, busy, done;
  logic [7:0] out_data;
  logic [1:0] out_col;
  logic [7:0] ops [N];
  logic [7:0] acc [N];
  logic start2 = 0;
  logic [15:0] acc_vec2;
  logic acc_clear2, feed_en2, out_valid2, busy2, done2;
  logic [7:0] out_data2;
  logic [0:0] out_col2;
  logic [7:0] ops2 [2];
  logic [7:0] acc2 [2];
  int errs = 0, checks = 0;
  logic [15:0] sb [$];
  bit mon_en = 0, exp_done = 0, held = 0;
  logic [7:0] hd;
  logic [1:0] hc;

  accumulator_drain_controller #(.N(N), .K(K), .CW(2)) dut (
    .clk(clk), .clear(clear), .start(start), .acc_vec(acc_vec), .acc_clear(acc_clear),
    .feed_en(feed_en), .out_data(out_data), .out_col(out_col), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy), .done(done));

  accumulator_drain_controller #(.N(2), .K(1), .CW(1)) u2 (
    .clk(clk), .clear(clear), .start(start2), .acc_vec(acc_vec2), .acc_clear(acc_clear2),
    .feed_en(feed_en2), .out_data(out_data2), .out_col(out_col2), .out_valid(out_valid2),
    .out_ready(1'b1), .busy(busy2), .done(done2));

  // accumulator row model: cleared by acc_clear, sums operands while fed
  always @(posedge clk) begin
    for (int c = 0; c < N; c++) acc[c] <= acc_clear ? 8'd0 : feed_en ? acc[c] + ops[c] : acc[c];
    for (int c = 0; c < 2; c++) acc2[c] <= acc_clear2 ? 8'd0 : feed_en2 ? acc2[c] + ops2[c] : acc2[c];
  end
  always_comb begin
    for (int c = 0; c < N; c++) acc_vec[8*c +: 8] = acc[c];
    for (int c = 0; c < 2; c++) acc_vec2[8*c +: 8] = acc2[c];
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard on every accepted beat, checks stall stability and done
  always @(negedge clk) if (mon_en) begin
    logic [15:0] e;
    bit x;
    chk("done", done, exp_done);
    if (held && out_valid) begin
      chk("stall_data", out_data, hd);
      chk("stall_col", out_col, hc);
    end
    x = out_valid && out_ready && !clear;
    exp_done = 0;
    if (x) begin
      if (sb.size() == 0) begin
        checks++; errs++;
        $display("FAIL beat_unexpected: got col %0d data 0x%0h with empty scoreboard", out_col, out_data);
      end else begin
        e = sb.pop_front();
        chk("beat_data", out_data, e[7:0]);
        chk("beat_col", out_col, e[15:8]);
        exp_done = e[15:8] == 8'(N - 1);
      end
    end
    held = out_valid && !out_ready && !clear;
    hd = out_data;
    hc = out_col;
  end

  // mode: 0 ramp c+1, 1 constant 100, 2 random; rm: 0 ready=1, 1 random, 2 scripted stall
  task automatic run_pass(input int mode, input bit tl, input int rm, input bit st, input bit ab);
    logic [7:0] s [N];
    logic [7:0] op;
    logic [4:0] ev;
    int t, d;
    bit fin;
    for (int c = 0; c < N; c++) s[c] = 0;
    @(posedge clk); #1;
    start = 1;
    out_ready = 1;
    @(posedge clk); #1;
    t = 1;
    fin = 0;
    while (!fin && t < 200) begin
      start = st && (t == 2 || t == K + 3);
      for (int c = 0; c < N; c++) begin
        op = mode == 0 ? 8'(c + 1) : mode == 1 ? 8'd100 : 8'($urandom_range(0, 255));
        ops[c] = t <= K ? op : 8'd0;
        if (t <= K) s[c] = s[c] + op;
        if (t == K) sb.push_back({8'(c), s[c]});
      end
      d = t - (K + 2);
      out_ready = rm == 0 ? 1'b1 : rm == 1 ? 1'($urandom_range(0, 1)) :
                  d <= 0 ? 1'b1 : d <= 3 ? 1'b0 : 1'((d - 4) % 2 == 0);
      if (ab) clear = t == K + 4;
      @(negedge clk);
      if (tl) begin
        ev = {1'(t > K + 1), 1'(t <= K), 1'(t >= K + 2 && t <= K + N + 1), 1'(t <= K + N + 1), 1'(t == K + N + 2)};
        chk("timeline", {acc_clear, feed_en, out_valid, busy, done}, ev);
      end
      if (ab && t == K + 4) sb.delete();
      if (ab && t == K + 5) begin
        chk("abort_state", {out_valid, acc_clear, out_col, busy, done}, 6'b010000);
        fin = 1;
      end
      if (rm == 2 && done) chk("bp_done_cycle", t, K + 11);
      if (done) fin = 1;
      @(posedge clk); #1;
      t++;
    end
    start = 0;
    if (!fin) begin
      checks++; errs++;
      $display("FAIL pass_timeout: no done after %0d cycles", t);
    end
  endtask

  task automatic k1n2();
    @(posedge clk); #1;
    start2 = 1;
    @(posedge clk); #1;
    start2 = 0;
    ops2[0] = 8'd7;
    ops2[1] = 8'd9;
    for (int t = 1; t <= 5; t++) begin
      @(negedge clk);
      chk("k1_valid", out_valid2, t == 3 || t == 4);
      if (t == 3) begin chk("k1_data0", out_data2, 7); chk("k1_col0", out_col2, 0); end
      if (t == 4) begin chk("k1_data1", out_data2, 9); chk("k1_col1", out_col2, 1); end
      chk("k1_done", done2, t == 5);
      @(posedge clk); #1;
      ops2[0] = 0;
      ops2[1] = 0;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int c = 0; c < N; c++) ops[c] = 0;
    ops2[0] = 0;
    ops2[1] = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ctrl", {acc_clear, feed_en, out_valid, busy, done}, 5'b10000);
    chk("reset_data", {out_data, out_col}, 0);
    chk("reset_u2", {acc_clear2, out_valid2, busy2, done2}, 4'b1000);
    @(posedge clk); #1;
    clear = 0;
    mon_en = 1;
    run_pass(0, 1, 0, 0, 0);
    run_pass(1, 1, 0, 0, 0);
    run_pass(2, 0, 2, 0, 0);
    run_pass(2, 1, 0, 1, 0);
    run_pass(2, 0, 0, 0, 1);
    repeat (8) run_pass(2, 0, 1, 0, 0);
    k1n2();
    repeat (3) @(posedge clk);
    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
